uart_rx_frame_checker: RTL and testbench

Parametrised UART receive framer that generalises the combinational parity checker into a full sequential receiver. It oversamples the serial line, assembles a frame of DATA_BITS data bits LSB-first, and handles an optional parity bit (even or odd) and one or two stop bits. It reports the received word with parity and framing status on a single-cycle valid pulse. It sits between the rx pad and the RX FIFO and is driven by the shared baud-tick generator.

---
 rtl/uart_rx_frame_checker.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_frame_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_checker.sv
// Oversampling UART receive framer: LSB-first data, optional even/odd parity,
// one or two stop bits, word and status reported on a one-clk valid pulse.
//
// state     | meaning
// IDLE      | line idle, waiting for a low sample on a baud tick
// START     | confirming the start bit at its centre
// DATA      | sampling DATA_BITS data bits at bit centres
// PARITY    | sampling the parity bit
// STOP1     | sampling the first stop bit
// STOP2     | sampling the second stop bit
// FINISH    | loading outputs and pulsing data_valid
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_type,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        FINISH,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 cfg_pen;
    logic                 cfg_ptype;
    logic                 cfg_two;
    logic                 perr;
    logic                 ferr;
    logic                 centre;

    // Bit centre for every bit after the start bit.
    assign centre = baud_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            cfg_pen       <= 1'b0;
            cfg_ptype     <= 1'b0;
            cfg_two       <= 1'b0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            data_valid <= 1'b0;

            if (baud_tick && (state == DATA || state == PARITY ||
                              state == STOP1 || state == STOP2)) begin
                tick_cnt <= centre ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (baud_tick && !rx_s) begin
                        state     <= START;
                        tick_cnt  <= '0;
                        cfg_pen   <= parity_en;
                        cfg_ptype <= parity_type;
                        cfg_two   <= two_stop;
                        perr      <= 1'b0;
                        ferr      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_HALF) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (centre) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= cfg_pen ? PARITY : STOP1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (centre) begin
                        perr  <= rx_s != ((^shreg) ^ cfg_ptype);
                        state <= STOP1;
                    end
                end
                STOP1: begin
                    if (centre) begin
                        ferr  <= !rx_s;
                        state <= cfg_two ? STOP2 : FINISH;
                    end
                end
                STOP2: begin
                    if (centre) begin
                        ferr  <= ferr | !rx_s;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    data_out      <= shreg;
                    parity_error  <= perr;
                    framing_error <= ferr;
                    data_valid    <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ferr ? WAIT_IDLE : IDLE;
                end
                WAIT_IDLE: begin
                    if (baud_tick && rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Self-checking bench for uart_rx_frame_checker: directed frame table, random
// frames against a bit-counting parity model, and multi-cycle corner sequences.
module tb_uart_rx_frame_checker;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          baud_tick;
    logic          rx;
    logic          parity_en;
    logic          parity_type;
    logic          two_stop;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          framing_error;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    logic [DB-1:0] cap_data = '0;
    logic          cap_perr = 1'b0;
    logic          cap_ferr = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [2:0]    tick_hist  = '0;
    logic          busy_seen  = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptype;
        logic       pbit;
        logic       ts;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    uart_rx_frame_checker #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx           (rx),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .two_stop     (two_stop),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                baud_tick = (i == 3);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every pulse: one clk wide, busy drops with it, and it trails a baud tick by 2 clks.
    always @(negedge clk) begin
        if (data_valid) begin
            pulses++;
            cap_data = data_out;
            cap_perr = parity_error;
            cap_ferr = framing_error;
            check("pulse_width", {31'd0, prev_valid}, 32'd0);
            check("busy_at_pulse", {31'd0, busy}, 32'd0);
            check("busy_before_pulse", {31'd0, prev_busy}, 32'd1);
            check("pulse_latency", {31'd0, tick_hist[1]}, 32'd1);
        end
        if (busy) busy_seen = 1'b1;
        prev_valid = data_valid;
        prev_busy  = busy;
        tick_hist  = {tick_hist[1:0], baud_tick};
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic ts, input logic s1, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (ts) send_bit(s2);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic pen,
                             input logic ptype, input logic pbit, input logic ts,
                             input logic s1, input logic s2, input logic [7:0] exp_d,
                             input logic exp_p, input logic exp_f);
        int p0;
        parity_en   = pen;
        parity_type = ptype;
        two_stop    = ts;
        p0 = pulses;
        send_frame(d, pen, pbit, ts, s1, s2);
        check({name, "_pulses"}, pulses - p0, 32'd1);
        check({name, "_data"}, {24'd0, cap_data}, {24'd0, exp_d});
        check({name, "_perr"}, {31'd0, cap_perr}, {31'd0, exp_p});
        check({name, "_ferr"}, {31'd0, cap_ferr}, {31'd0, exp_f});
    endtask

    initial begin
        int p0;
        logic [7:0] d;
        logic pen, ptype, pbit, ts, s1, s2, ep, ef;
        int ones;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};
        vecs[2] = '{8'hF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF8, 1'b1, 1'b0};
        vecs[3] = '{8'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[4] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[7] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};

        rst = 1'b1;
        rx = 1'b1;
        parity_en = 1'b0;
        parity_type = 1'b0;
        two_stop = 1'b0;
        wait_clks(5);
        rst = 1'b0;
        check("reset_data", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_perr", {31'd0, parity_error}, 32'd0);
        check("reset_ferr", {31'd0, framing_error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        wait_clks(2 * BIT_CLKS);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("table%0d", i), vecs[i].data, vecs[i].pen, vecs[i].ptype,
                      vecs[i].pbit, vecs[i].ts, vecs[i].s1, vecs[i].s2,
                      vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // parity_type flipped after the start bit must not affect this frame
        parity_en = 1'b1;
        parity_type = 1'b1;
        two_stop = 1'b0;
        p0 = pulses;
        send_bit(1'b0);
        parity_type = 1'b0;
        d = 8'hCC;
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("toggle_pulses", pulses - p0, 32'd1);
        check("toggle_data", {24'd0, cap_data}, 32'h0000_00CC);
        check("toggle_perr", {31'd0, cap_perr}, 32'd0);

        for (int n = 0; n < 12; n++) begin
            d     = 8'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            pbit  = 1'($urandom);
            ts    = 1'($urandom);
            s1    = ($urandom_range(0, 4) != 0);
            s2    = ($urandom_range(0, 4) != 0);
            ones = 0;
            for (int b = 0; b < DB; b++) ones += d[b];
            ep = pen && (((ones + pbit) % 2) != ptype);
            ef = !s1 || (ts && !s2);
            run_frame($sformatf("rand%0d", n), d, pen, ptype, pbit, ts, s1, s2, d, ep, ef);
        end

        // leave both flags set so the reset check below has something to clear
        run_frame("pre_reset", 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF8, 1'b1, 1'b1);

        parity_en = 1'b0;
        two_stop = 1'b0;
        p0 = pulses;
        d = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("midrst_data", {24'd0, data_out}, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_perr", {31'd0, parity_error}, 32'd0);
        check("midrst_ferr", {31'd0, framing_error}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("midrst_no_pulse", pulses - p0, 32'd0);
        run_frame("post_reset", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);

        parity_en = 1'b0;
        two_stop = 1'b0;
        p0 = pulses;
        rx = 1'b0;
        wait_clks(30 * BIT_CLKS);
        check("break_pulses", pulses - p0, 32'd1);
        check("break_data", {24'd0, cap_data}, 32'd0);
        check("break_ferr", {31'd0, cap_ferr}, 32'd1);
        check("break_perr", {31'd0, cap_perr}, 32'd0);
        check("break_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("break_release_pulses", pulses - p0, 32'd1);

        p0 = pulses;
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_no_pulse", pulses - p0, 32'd0);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_ferr_kept", {31'd0, framing_error}, 32'd1);
        check("glitch_data_kept", {24'd0, data_out}, 32'd0);

        run_frame("final", 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
